// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the multicycle control unit.
//   state_t   : 5-bit FSM state encoding (visible on dbg_state)
//   cause_t   : exception cause codes driven on Cause
//   aluop_t   : selector for alu_decoder
//   ALU_*, OP_*, F_* : the same encodings the existing datapath uses
package cpu_ctrl_pkg;

    // ALU operation codes
    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_XOR = 4'd2;
    localparam logic [3:0] ALU_NOR = 4'd3;
    localparam logic [3:0] ALU_ADD = 4'd4;
    localparam logic [3:0] ALU_SUB = 4'd5;
    localparam logic [3:0] ALU_SLT = 4'd6;
    localparam logic [3:0] ALU_SLL = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8;
    localparam logic [3:0] ALU_SRA = 4'd9;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] F_SLL = 6'h00;
    localparam logic [5:0] F_SRL = 6'h02;
    localparam logic [5:0] F_SRA = 6'h03;
    localparam logic [5:0] F_JR  = 6'h08;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_XOR = 6'h26;
    localparam logic [5:0] F_NOR = 6'h27;
    localparam logic [5:0] F_SLT = 6'h2A;

    // PCSrc encodings
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REG    = 2'b11;

    // ALUSrcB encodings
    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

    typedef enum logic [4:0] {
        StFetch  = 5'd0,
        StDwait  = 5'd1,
        StDecode = 5'd2,
        StAddr   = 5'd3,
        StMemRd  = 5'd4,
        StMemWb  = 5'd5,
        StMemWr  = 5'd6,
        StExec   = 5'd7,
        StAluwb  = 5'd8,
        StBranch = 5'd9,
        StExi    = 5'd10,
        StWbi    = 5'd11,
        StJump   = 5'd12,
        StExc    = 5'd13
    } state_t;

    typedef enum logic [1:0] {
        CauseNone    = 2'b00,
        CauseIllegal = 2'b01,
        CauseBus     = 2'b10
    } cause_t;

    typedef enum logic [1:0] {
        AluOpAdd   = 2'b00,
        AluOpSub   = 2'b01,
        AluOpFunct = 2'b10,
        AluOpImm   = 2'b11
    } aluop_t;

    function automatic logic is_legal_r_funct(input logic [5:0] funct);
        case (funct)
            F_AND, F_OR, F_XOR, F_NOR, F_ADD, F_SUB, F_SLT,
            F_SLL, F_SRL, F_SRA, F_JR: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_hs_alu_decoder.sv
// Combinational ALU control decode.
//   aluop       : AluOpAdd/AluOpSub force the op; AluOpFunct decodes funct (R-type);
//                 AluOpImm decodes opcode (immediate ALU instructions)
//   funct       : instruction[5:0]
//   opcode      : instruction[31:26]
//   alu_control : ALU_* code
module alu_decoder
    import cpu_ctrl_pkg::*;
(
    input  aluop_t     aluop,
    input  logic [5:0] funct,
    input  logic [5:0] opcode,
    output logic [3:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        unique case (aluop)
            AluOpAdd: alu_control = ALU_ADD;
            AluOpSub: alu_control = ALU_SUB;
            AluOpFunct: begin
                case (funct)
                    F_AND:   alu_control = ALU_AND;
                    F_OR:    alu_control = ALU_OR;
                    F_XOR:   alu_control = ALU_XOR;
                    F_NOR:   alu_control = ALU_NOR;
                    F_ADD:   alu_control = ALU_ADD;
                    F_SUB:   alu_control = ALU_SUB;
                    F_SLT:   alu_control = ALU_SLT;
                    F_SLL:   alu_control = ALU_SLL;
                    F_SRL:   alu_control = ALU_SRL;
                    F_SRA:   alu_control = ALU_SRA;
                    default: alu_control = ALU_ADD;
                endcase
            end
            AluOpImm: begin
                case (opcode)
                    OP_ANDI: alu_control = ALU_AND;
                    OP_ORI:  alu_control = ALU_OR;
                    OP_XORI: alu_control = ALU_XOR;
                    OP_SLTI: alu_control = ALU_SLT;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/control_unit_hs.sv
// Multicycle MIPS control FSM with a mem_ready handshake on every memory access,
// an optional decode-settle delay, a bus-timeout trap and an illegal-opcode trap.
// Inputs : clk, rst (async, active-high), clk_en (advance enable), opcode, funct,
//          mem_ready (current access completes this cycle)
// Outputs: datapath strobes/selects (MemRead ... ALUControl), exception controls
//          (ExcPC, EPCWrite, CauseWrite, Cause) and dbg_state.
// Outputs are combinational from state, opcode, funct and mem_ready; rst forces
// every output to its idle default without waiting for a clock edge.
module control_unit_hs
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned DECODE_WAIT    = 1,
    parameter int unsigned MEM_TIMEOUT    = 16,
    parameter int unsigned EXC_ON_ILLEGAL = 1,
    parameter int unsigned CNT_W          = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       MemToReg,
    output logic       RegDst,
    output logic       ExtOp,
    output logic       UseShamt,
    output logic       WriteRA,
    output logic       BranchEQ,
    output logic       BranchNE,
    output logic [1:0] PCSrc,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUControl,
    output logic       ExcPC,
    output logic       EPCWrite,
    output logic       CauseWrite,
    output logic [1:0] Cause,
    output logic [4:0] dbg_state
);

    localparam logic [CNT_W-1:0] DwLast =
        CNT_W'((DECODE_WAIT > 0) ? DECODE_WAIT - 1 : 0);
    localparam logic [CNT_W-1:0] TimeoutLast =
        CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    cause_t           cause_q;

    state_t           decode_next;
    logic             timeout_hit;
    logic [CNT_W-1:0] cnt_inc;
    aluop_t           aluop;

    assign cnt_inc     = cnt_q + CNT_W'(1);
    // Only meaningful when mem_ready is low; a ready in the last cycle wins.
    assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_q == TimeoutLast);
    assign dbg_state   = state_q;

    // DECODE dispatch
    always_comb begin
        logic illegal;
        illegal     = 1'b0;
        decode_next = StFetch;
        case (opcode)
            OP_RTYPE: begin
                if (funct == F_JR)                decode_next = StJump;
                else if (is_legal_r_funct(funct)) decode_next = StExec;
                else                              illegal     = 1'b1;
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: decode_next = StExi;
            OP_LW, OP_SW:                               decode_next = StAddr;
            OP_BEQ, OP_BNE:                             decode_next = StBranch;
            OP_J, OP_JAL:                               decode_next = StJump;
            default:                                    illegal     = 1'b1;
        endcase
        if (illegal) decode_next = (EXC_ON_ILLEGAL != 0) ? StExc : StFetch;
    end

    // Counter defaults to clear so every state entry starts it from zero; only the
    // self-looping wait states let it advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
            cnt_q   <= '0;
            cause_q <= CauseNone;
        end else if (clk_en) begin
            cnt_q <= '0;
            unique case (state_q)
                StFetch: begin
                    if (mem_ready) begin
                        state_q <= (DECODE_WAIT == 0) ? StDecode : StDwait;
                    end else if (timeout_hit) begin
                        state_q <= StExc;
                        cause_q <= CauseBus;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                StDwait: begin
                    if (cnt_q == DwLast) state_q <= StDecode;
                    else                 cnt_q   <= cnt_inc;
                end
                StDecode: begin
                    state_q <= decode_next;
                    if (decode_next == StExc) cause_q <= CauseIllegal;
                end
                StAddr: state_q <= (opcode == OP_SW) ? StMemWr : StMemRd;
                StMemRd: begin
                    if (mem_ready) begin
                        state_q <= StMemWb;
                    end else if (timeout_hit) begin
                        state_q <= StExc;
                        cause_q <= CauseBus;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                StMemWr: begin
                    if (mem_ready) begin
                        state_q <= StFetch;
                    end else if (timeout_hit) begin
                        state_q <= StExc;
                        cause_q <= CauseBus;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                StMemWb: state_q <= StWbi;
                StExec:  state_q <= StAluwb;
                StExi:   state_q <= StWbi;
                // ALUWB, BRANCH, WBI, JUMP and EXC all return to FETCH
                default: state_q <= StFetch;
            endcase
        end
    end

    always_comb begin
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IorD       = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        ALUSrcA    = 1'b0;
        RegWrite   = 1'b0;
        MemToReg   = 1'b0;
        RegDst     = 1'b0;
        ExtOp      = 1'b1;
        UseShamt   = 1'b0;
        WriteRA    = 1'b0;
        BranchEQ   = 1'b0;
        BranchNE   = 1'b0;
        PCSrc      = PCSRC_ALU;
        ALUSrcB    = SRCB_REG;
        ExcPC      = 1'b0;
        EPCWrite   = 1'b0;
        CauseWrite = 1'b0;
        Cause      = CauseNone;
        aluop      = AluOpAdd;
        if (!rst) begin
            unique case (state_q)
                StFetch: begin
                    MemRead = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                    PCWrite = mem_ready;
                    IRWrite = mem_ready;
                end
                // Branch target is precomputed while decoding
                StDwait, StDecode: ALUSrcB = SRCB_IMM_SL2;
                StAddr: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                end
                StMemRd: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                StMemWr: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                StMemWb: ;
                StExec: begin
                    ALUSrcA  = 1'b1;
                    aluop    = AluOpFunct;
                    UseShamt = (funct == F_SLL) || (funct == F_SRL) || (funct == F_SRA);
                end
                StAluwb: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                StBranch: begin
                    ALUSrcA  = 1'b1;
                    aluop    = AluOpSub;
                    PCSrc    = PCSRC_BRANCH;
                    BranchEQ = (opcode == OP_BEQ);
                    BranchNE = (opcode == OP_BNE);
                end
                StExi: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                    aluop   = AluOpImm;
                    // Logical immediates are zero-extended
                    ExtOp   = !((opcode == OP_ANDI) || (opcode == OP_ORI) ||
                                (opcode == OP_XORI));
                end
                StWbi: begin
                    RegWrite = 1'b1;
                    MemToReg = (opcode == OP_LW);
                end
                StJump: begin
                    PCWrite  = 1'b1;
                    PCSrc    = (opcode == OP_RTYPE) ? PCSRC_REG : PCSRC_JUMP;
                    RegWrite = (opcode == OP_JAL);
                    WriteRA  = (opcode == OP_JAL);
                end
                StExc: begin
                    ExcPC      = 1'b1;
                    PCWrite    = 1'b1;
                    EPCWrite   = 1'b1;
                    CauseWrite = 1'b1;
                    Cause      = cause_q;
                end
                default: ;
            endcase
        end
    end

    alu_decoder u_alu_decoder (
        .aluop       (aluop),
        .funct       (funct),
        .opcode      (opcode),
        .alu_control (ALUControl)
    );

endmodule

// File: tb/tb_control_unit_hs.sv
module tb_control_unit_hs;
    import cpu_ctrl_pkg::*;

    localparam int unsigned DW = 1;
    localparam int unsigned TO = 4;

    localparam int KR = 0, KJR = 1, KI = 2, KLW = 3, KSW = 4, KBR = 5, KJ = 6,
                   KJAL = 7, KILL = 8;

    logic clk = 1'b0;
    logic rst, clk_en, mem_ready;
    logic [5:0] opcode, funct;
    logic MemRead, MemWrite, IorD, IRWrite, PCWrite, ALUSrcA, RegWrite, MemToReg;
    logic RegDst, ExtOp, UseShamt, WriteRA, BranchEQ, BranchNE, ExcPC, EPCWrite;
    logic CauseWrite;
    logic [1:0] PCSrc, ALUSrcB, Cause;
    logic [3:0] ALUControl;
    logic [4:0] dbg_state;

    // Second instance: no decode wait, no timeout, illegal opcodes ignored
    logic clk_en2, mem_ready2;
    logic [5:0] opcode2, funct2;
    logic b_MemRead, b_MemWrite, b_IorD, b_IRWrite, b_PCWrite, b_ALUSrcA, b_RegWrite;
    logic b_MemToReg, b_RegDst, b_ExtOp, b_UseShamt, b_WriteRA, b_BranchEQ, b_BranchNE;
    logic b_ExcPC, b_EPCWrite, b_CauseWrite;
    logic [1:0] b_PCSrc, b_ALUSrcB, b_Cause;
    logic [3:0] b_ALUControl;
    logic [4:0] b_dbg_state;

    always #5 clk = ~clk;

    control_unit_hs #(.DECODE_WAIT(DW), .MEM_TIMEOUT(TO), .EXC_ON_ILLEGAL(1), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .opcode(opcode), .funct(funct),
        .mem_ready(mem_ready), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
        .MemToReg(MemToReg), .RegDst(RegDst), .ExtOp(ExtOp), .UseShamt(UseShamt),
        .WriteRA(WriteRA), .BranchEQ(BranchEQ), .BranchNE(BranchNE), .PCSrc(PCSrc),
        .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ExcPC(ExcPC), .EPCWrite(EPCWrite),
        .CauseWrite(CauseWrite), .Cause(Cause), .dbg_state(dbg_state)
    );

    control_unit_hs #(.DECODE_WAIT(0), .MEM_TIMEOUT(0), .EXC_ON_ILLEGAL(0), .CNT_W(5)) dut2 (
        .clk(clk), .rst(rst), .clk_en(clk_en2), .opcode(opcode2), .funct(funct2),
        .mem_ready(mem_ready2), .MemRead(b_MemRead), .MemWrite(b_MemWrite),
        .IorD(b_IorD), .IRWrite(b_IRWrite), .PCWrite(b_PCWrite), .ALUSrcA(b_ALUSrcA),
        .RegWrite(b_RegWrite), .MemToReg(b_MemToReg), .RegDst(b_RegDst),
        .ExtOp(b_ExtOp), .UseShamt(b_UseShamt), .WriteRA(b_WriteRA),
        .BranchEQ(b_BranchEQ), .BranchNE(b_BranchNE), .PCSrc(b_PCSrc),
        .ALUSrcB(b_ALUSrcB), .ALUControl(b_ALUControl), .ExcPC(b_ExcPC),
        .EPCWrite(b_EPCWrite), .CauseWrite(b_CauseWrite), .Cause(b_Cause),
        .dbg_state(b_dbg_state)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One expected cycle of the instruction timeline
    typedef struct {
        state_t     st;
        logic       rdy;
        logic [1:0] cause;
    } rec_t;

    rec_t plan[$];
    int   cur_kind;
    logic [5:0] cur_op, cur_fn;

    logic [5:0] rfn  [10] = '{F_AND, F_OR, F_XOR, F_NOR, F_ADD, F_SUB, F_SLT,
                              F_SLL, F_SRL, F_SRA};
    logic [5:0] iops [5]  = '{OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI};

    function automatic logic [3:0] exp_alu(input logic [5:0] op, input logic [5:0] fn);
        if (op == OP_RTYPE) begin
            case (fn)
                F_AND: return ALU_AND;  F_OR:  return ALU_OR;   F_XOR: return ALU_XOR;
                F_NOR: return ALU_NOR;  F_SUB: return ALU_SUB;  F_SLT: return ALU_SLT;
                F_SLL: return ALU_SLL;  F_SRL: return ALU_SRL;  F_SRA: return ALU_SRA;
                default: return ALU_ADD;
            endcase
        end
        case (op)
            OP_ANDI: return ALU_AND;
            OP_ORI:  return ALU_OR;
            OP_XORI: return ALU_XOR;
            OP_SLTI: return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    // {MemRead, MemWrite, IRWrite, PCWrite, RegWrite, EPCWrite, CauseWrite, ExcPC, Cause}
    function automatic logic [9:0] exp_vec(input state_t st, input logic rdy,
                                           input logic [1:0] cause, input int kind);
        logic mr = 0, mw = 0, ir = 0, pw = 0, rw = 0, ew = 0, cw = 0, ex = 0;
        logic [1:0] c = 2'b00;
        case (st)
            StFetch:         begin mr = 1; ir = rdy; pw = rdy; end
            StMemRd:         mr = 1;
            StMemWr:         mw = 1;
            StAluwb, StWbi:  rw = 1;
            StJump:          begin pw = 1; rw = (kind == KJAL); end
            StExc:           begin pw = 1; ew = 1; cw = 1; ex = 1; c = cause; end
            default: ;
        endcase
        return {mr, mw, ir, pw, rw, ew, cw, ex, c};
    endfunction

    function automatic rec_t mk(input state_t st, input logic rdy, input logic [1:0] c);
        rec_t r;
        r.st = st; r.rdy = rdy; r.cause = c;
        return r;
    endfunction

    // Memory phase: lat not-ready cycles then ready, or a trap after TO cycles.
    // Returns 1 if the access completed.
    function automatic bit add_mem(input state_t st, input int lat);
        if (lat >= int'(TO)) begin
            repeat (TO) plan.push_back(mk(st, 1'b0, 2'b00));
            plan.push_back(mk(StExc, 1'b0, 2'b10));
            return 1'b0;
        end
        repeat (lat) plan.push_back(mk(st, 1'b0, 2'b00));
        plan.push_back(mk(st, 1'b1, 2'b00));
        return 1'b1;
    endfunction

    task automatic build(input int kind, input int flat, input int dlat);
        plan.delete();
        cur_kind = kind;
        case (kind)
            KR:   begin cur_op = OP_RTYPE; cur_fn = rfn[$urandom_range(0, 9)]; end
            KJR:  begin cur_op = OP_RTYPE; cur_fn = F_JR; end
            KI:   begin cur_op = iops[$urandom_range(0, 4)]; cur_fn = 6'($urandom); end
            KLW:  begin cur_op = OP_LW;  cur_fn = 6'($urandom); end
            KSW:  begin cur_op = OP_SW;  cur_fn = 6'($urandom); end
            KBR:  begin cur_op = $urandom_range(0, 1) ? OP_BEQ : OP_BNE; cur_fn = 6'($urandom); end
            KJ:   begin cur_op = OP_J;   cur_fn = 6'($urandom); end
            KJAL: begin cur_op = OP_JAL; cur_fn = 6'($urandom); end
            default: begin
                case ($urandom_range(0, 2))
                    0:       begin cur_op = 6'h3F; cur_fn = 6'h00; end
                    1:       begin cur_op = 6'h10; cur_fn = 6'h20; end
                    default: begin cur_op = OP_RTYPE; cur_fn = 6'h01; end
                endcase
            end
        endcase
        if (!add_mem(StFetch, flat)) return;
        repeat (DW) plan.push_back(mk(StDwait, 1'b0, 2'b00));
        plan.push_back(mk(StDecode, 1'b0, 2'b00));
        case (kind)
            KR:  begin plan.push_back(mk(StExec, 0, 0)); plan.push_back(mk(StAluwb, 0, 0)); end
            KI:  begin plan.push_back(mk(StExi, 0, 0));  plan.push_back(mk(StWbi, 0, 0)); end
            KLW: begin
                plan.push_back(mk(StAddr, 0, 0));
                if (add_mem(StMemRd, dlat)) begin
                    plan.push_back(mk(StMemWb, 0, 0));
                    plan.push_back(mk(StWbi, 0, 0));
                end
            end
            KSW: begin
                plan.push_back(mk(StAddr, 0, 0));
                void'(add_mem(StMemWr, dlat));
            end
            KBR:              plan.push_back(mk(StBranch, 0, 0));
            KJR, KJ, KJAL:    plan.push_back(mk(StJump, 0, 0));
            default:          plan.push_back(mk(StExc, 0, 2'b01));
        endcase
    endtask

    // Drive and check the plan cycle by cycle; clk_en randomly stalls the FSM.
    task automatic run_plan(input bit use_stop, input state_t stop_st);
        int guard = 0;
        while (plan.size() > 0) begin
            rec_t r = plan[0];
            logic en;
            if (use_stop && r.st == stop_st) break;
            if (guard++ > 2000) begin
                check("plan_budget", 32'd1, 32'd0);
                break;
            end
            en       = ($urandom_range(0, 4) != 0);
            clk_en   = en;
            opcode   = cur_op;
            funct    = cur_fn;
            if (r.st == StFetch || r.st == StMemRd || r.st == StMemWr)
                mem_ready = en ? r.rdy : 1'b0;
            else
                mem_ready = 1'($urandom_range(0, 1));
            #3;
            check("state", dbg_state, r.st);
            check("strobes", {MemRead, MemWrite, IRWrite, PCWrite, RegWrite, EPCWrite,
                              CauseWrite, ExcPC, Cause},
                  exp_vec(r.st, mem_ready, r.cause, cur_kind));
            case (r.st)
                StAluwb:  check("regdst", RegDst, 1'b1);
                StWbi:    check("memtoreg", MemToReg, cur_kind == KLW);
                StJump: begin
                    check("writera", WriteRA, cur_kind == KJAL);
                    check("pcsrc", PCSrc, (cur_kind == KJR) ? 2'b11 : 2'b10);
                end
                StExec, StExi: check("aluctl", ALUControl, exp_alu(cur_op, cur_fn));
                StBranch: check("branch", {BranchEQ, BranchNE},
                                {cur_op == OP_BEQ, cur_op == OP_BNE});
                StMemRd, StMemWr: check("iord", IorD, 1'b1);
                default: ;
            endcase
            @(posedge clk);
            #1;
            if (en) void'(plan.pop_front());
        end
    endtask

    task automatic step2(input string tag, input state_t st, input logic rdy);
        mem_ready2 = rdy;
        #3;
        check({tag, "_st"}, b_dbg_state, st);
        check({tag, "_exc"}, {b_EPCWrite, b_CauseWrite, b_ExcPC}, 3'b000);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b1; mem_ready = 1'b0; opcode = '0; funct = '0;
        clk_en2 = 1'b1; mem_ready2 = 1'b0; opcode2 = '0; funct2 = '0;
        #3;
        check("rst_state", dbg_state, StFetch);
        check("rst_strobes", {MemRead, MemWrite, IRWrite, PCWrite, RegWrite, EPCWrite,
                              CauseWrite}, 7'd0);
        check("rst_alu", ALUControl, ALU_ADD);
        check("rst_extop", ExtOp, 1'b1);
        check("rst_cause", Cause, 2'b00);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 300; i++) begin
            build($urandom_range(0, 8), $urandom_range(0, 5), $urandom_range(0, 5));
            run_plan(1'b0, StFetch);
        end

        // Second instance sat in FETCH with no ready the whole time: must not trap
        check("b_no_timeout", b_dbg_state, StFetch);
        opcode2 = 6'h3F;
        step2("b_ill_f", StFetch, 1'b1);
        step2("b_ill_d", StDecode, 1'b0);
        step2("b_ill_back", StFetch, 1'b0);
        opcode2 = OP_RTYPE; funct2 = F_ADD;
        step2("b_add_f", StFetch, 1'b1);
        step2("b_add_d", StDecode, 1'b0);
        step2("b_add_x", StExec, 1'b0);
        step2("b_add_w", StAluwb, 1'b0);
        step2("b_add_back", StFetch, 1'b0);

        // Reset in the middle of a data read
        build(KLW, 0, 3);
        run_plan(1'b1, StMemRd);
        plan.delete();
        clk_en = 1'b1; mem_ready = 1'b0;
        #2;
        check("rd_before_rst", {dbg_state, MemRead}, {StMemRd, 1'b1});
        rst = 1'b1;
        #1;
        check("rst_drop_read", {MemRead, IorD}, 2'b00);
        check("rst_async_state", dbg_state, StFetch);
        check("rst_mid_cause", Cause, 2'b00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #3;
        check("post_rst", {dbg_state, MemRead}, {StFetch, 1'b1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
